// File: rtl/keyboard_ascii_queue_if.sv
// Keyboard-to-LC-3 character queue bus: scancode input side plus KBSR/KBDR read side.
interface keyboard_ascii_queue_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    KeyCode;
    logic          KeyDown;
    logic          Pop;
    logic          Ready;
    logic [7:0]    Data;
    logic [CW-1:0] Count;
    logic          Overflow;
    logic          CapsLock;

    // Driver / register-file side
    modport master (
        output KeyCode, KeyDown, Pop,
        input  Ready, Data, Count, Overflow, CapsLock
    );

    // Queue block side
    modport slave (
        input  KeyCode, KeyDown, Pop,
        output Ready, Data, Count, Overflow, CapsLock
    );
endinterface

// File: rtl/keyboard_ascii_queue.sv
// Scancode-to-ASCII translator with Shift/Ctrl/Caps tracking feeding a small
// character FIFO read by the LC-3 KBSR/KBDR registers.
module keyboard_ascii_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    keyboard_ascii_queue_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    r_code_q, r_code_qq;
    logic          r_down_q, r_down_qq;
    logic          r_shift_l, r_shift_r, r_ctrl, r_caps;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_code_chg, w_make, w_break, w_shift;
    logic          w_lut_valid, w_lut_letter;
    logic [7:0]    w_lut_plain, w_lut_shift, w_char;
    logic          w_push_req, w_full, w_empty, w_pop_ok, w_push_ok, w_ovf_set;

    // Two-deep input pipeline for edge/event detection
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_code_q  <= 8'h00;
            r_code_qq <= 8'h00;
            r_down_q  <= 1'b0;
            r_down_qq <= 1'b0;
        end else begin
            r_code_q  <= bus.KeyCode;
            r_code_qq <= r_code_q;
            r_down_q  <= bus.KeyDown;
            r_down_qq <= r_down_q;
        end
    end

    assign w_code_chg = (r_code_q != r_code_qq);
    assign w_make     = r_down_q & (~r_down_qq | w_code_chg);
    assign w_break    = ~r_down_q & (r_down_qq | w_code_chg);
    assign w_shift    = r_shift_l | r_shift_r;

    // Modifier state: Shift/Ctrl follow make/break, Caps toggles on make only
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_shift_l <= 1'b0;
            r_shift_r <= 1'b0;
            r_ctrl    <= 1'b0;
            r_caps    <= 1'b0;
        end else if (w_make) begin
            case (r_code_q)
                8'h12:   r_shift_l <= 1'b1;
                8'h59:   r_shift_r <= 1'b1;
                8'h14:   r_ctrl    <= 1'b1;
                8'h58:   r_caps    <= ~r_caps;
                default: ;
            endcase
        end else if (w_break) begin
            case (r_code_q)
                8'h12:   r_shift_l <= 1'b0;
                8'h59:   r_shift_r <= 1'b0;
                8'h14:   r_ctrl    <= 1'b0;
                default: ;
            endcase
        end
    end

    // Set-2 scancode LUT: {valid, is_letter, plain glyph, shifted glyph}
    always_comb begin
        {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = 18'h0;
        case (r_code_q)
            8'h1C: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h61, 8'h41};
            8'h32: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h62, 8'h42};
            8'h21: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h63, 8'h43};
            8'h23: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h64, 8'h44};
            8'h24: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h65, 8'h45};
            8'h2B: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h66, 8'h46};
            8'h34: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h67, 8'h47};
            8'h33: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h68, 8'h48};
            8'h43: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h69, 8'h49};
            8'h3B: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h6A, 8'h4A};
            8'h42: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h6B, 8'h4B};
            8'h4B: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h6C, 8'h4C};
            8'h3A: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h6D, 8'h4D};
            8'h31: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h6E, 8'h4E};
            8'h44: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h6F, 8'h4F};
            8'h4D: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h70, 8'h50};
            8'h15: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h71, 8'h51};
            8'h2D: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h72, 8'h52};
            8'h1B: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h73, 8'h53};
            8'h2C: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h74, 8'h54};
            8'h3C: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h75, 8'h55};
            8'h2A: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h76, 8'h56};
            8'h1D: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h77, 8'h57};
            8'h22: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h78, 8'h58};
            8'h35: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h79, 8'h59};
            8'h1A: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b11, 8'h7A, 8'h5A};
            8'h16: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h31, 8'h21};
            8'h1E: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h32, 8'h40};
            8'h26: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h33, 8'h23};
            8'h25: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h34, 8'h24};
            8'h2E: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h35, 8'h25};
            8'h36: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h36, 8'h5E};
            8'h3D: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h37, 8'h26};
            8'h3E: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h38, 8'h2A};
            8'h46: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h39, 8'h28};
            8'h45: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h30, 8'h29};
            8'h4E: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h2D, 8'h5F};
            8'h55: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h3D, 8'h2B};
            8'h54: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h5B, 8'h7B};
            8'h5B: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h5D, 8'h7D};
            8'h4C: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h3B, 8'h3A};
            8'h52: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h27, 8'h22};
            8'h41: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h2C, 8'h3C};
            8'h49: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h2E, 8'h3E};
            8'h4A: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h2F, 8'h3F};
            8'h5D: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h5C, 8'h7C};
            8'h0E: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h60, 8'h7E};
            8'h29: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h20, 8'h20};
            8'h5A: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h0A, 8'h0A};
            8'h66: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h08, 8'h08};
            8'h0D: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h09, 8'h09};
            8'h76: {w_lut_valid, w_lut_letter, w_lut_plain, w_lut_shift} = {2'b10, 8'h1B, 8'h1B};
            default: ;
        endcase
    end

    // Apply modifiers: Ctrl folds letters to control codes, Caps only affects letters
    always_comb begin
        w_char = w_lut_plain;
        if (w_lut_letter) begin
            if (r_ctrl)                 w_char = w_lut_shift & 8'h1F;
            else if (w_shift ^ r_caps)  w_char = w_lut_shift;
        end else if (w_shift) begin
            w_char = w_lut_shift;
        end
    end

    assign w_push_req = w_make & w_lut_valid;
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop_ok   = bus.Pop & ~w_empty;
    assign w_push_ok  = w_push_req & (~w_full | w_pop_ok);
    assign w_ovf_set  = w_push_req & w_full & ~bus.Pop;

    // FIFO pointers, occupancy and sticky overflow (set beats clear)
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + CW'(1);
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - CW'(1);
            if (w_ovf_set)     r_overflow <= 1'b1;
            else if (w_pop_ok) r_overflow <= 1'b0;
        end
    end

    // Character storage; contents are don't-care after reset
    always_ff @(posedge Clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_char;
    end

    assign bus.Ready    = ~w_empty;
    assign bus.Data     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.Count    = r_count;
    assign bus.Overflow = r_overflow;
    assign bus.CapsLock = r_caps;
endmodule

// File: tb/tb_keyboard_ascii_queue.sv
// Scoreboard bench for keyboard_ascii_queue: stimulus queues expected ASCII,
// a monitor compares Data against the queue on every accepted Pop.
module tb_keyboard_ascii_queue;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] exp_q[$];

    keyboard_ascii_queue_if #(.DEPTH(DEPTH)) bus ();

    keyboard_ascii_queue #(.DEPTH(DEPTH)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [7:0] code, input logic down, input int n);
        bus.KeyCode = code;
        bus.KeyDown = down;
        tick(n);
    endtask

    task automatic press(input logic [7:0] code);
        ev(code, 1'b1, 2);
        ev(code, 1'b0, 2);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.Pop = 1'b1;
            tick(1);
        end
        bus.Pop = 1'b0;
    endtask

    // Monitor: each accepted pop must deliver the oldest expected character
    always @(negedge clk) begin
        if (rst_n && bus.Pop && bus.Ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_char", 32'(bus.Data), 32'h100);
            end else begin
                chk("pop_data", 32'(bus.Data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] codes [9];
        n_checks = 0;
        n_fail   = 0;
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        bus.KeyCode = 8'h00;
        bus.KeyDown = 1'b0;
        bus.Pop     = 1'b0;
        rst_n       = 1'b0;
        tick(3);
        chk("rst_ready", 32'(bus.Ready), 0);
        chk("rst_data", 32'(bus.Data), 0);
        chk("rst_count", 32'(bus.Count), 0);
        chk("rst_ovf", 32'(bus.Overflow), 0);
        chk("rst_caps", 32'(bus.CapsLock), 0);
        rst_n = 1'b1;
        tick(1);

        // Single make: 'a' ready two edges later
        exp_q.push_back(8'h61);
        ev(8'h1C, 1'b1, 2);
        chk("a_ready", 32'(bus.Ready), 1);
        chk("a_data", 32'(bus.Data), 32'h61);
        chk("a_count", 32'(bus.Count), 1);
        ev(8'h1C, 1'b0, 2);
        pop_n(1);
        chk("a_pop_ready", 32'(bus.Ready), 0);
        chk("a_pop_data", 32'(bus.Data), 0);

        // Shift held around a letter; modifiers push nothing
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h61);
        ev(8'h12, 1'b1, 2);
        chk("shift_no_push", 32'(bus.Count), 0);
        ev(8'h1C, 1'b1, 2);
        ev(8'h1C, 1'b0, 2);
        ev(8'h12, 1'b0, 2);
        ev(8'h1C, 1'b1, 2);
        ev(8'h1C, 1'b0, 2);
        chk("shift_count", 32'(bus.Count), 2);
        pop_n(2);

        // Caps + Shift cancel on letters, Shift digit, Ctrl-C
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h03);
        ev(8'h58, 1'b1, 2);
        ev(8'h58, 1'b0, 2);
        chk("caps_on", 32'(bus.CapsLock), 1);
        ev(8'h12, 1'b1, 2);
        ev(8'h1C, 1'b1, 2);
        ev(8'h16, 1'b1, 2);
        ev(8'h14, 1'b1, 2);
        ev(8'h21, 1'b1, 2);
        ev(8'h21, 1'b0, 2);
        ev(8'h14, 1'b0, 2);
        ev(8'h12, 1'b0, 2);
        chk("mod_count", 32'(bus.Count), 3);
        ev(8'h58, 1'b1, 2);
        ev(8'h58, 1'b0, 2);
        chk("caps_off", 32'(bus.CapsLock), 0);
        pop_n(3);

        // Held key yields one make only
        exp_q.push_back(8'h61);
        ev(8'h1C, 1'b1, 100);
        chk("hold_count", 32'(bus.Count), 1);
        ev(8'h1C, 1'b0, 2);
        pop_n(1);
        chk("hold_drained", 32'(bus.Count), 0);

        // Fill past capacity: ninth letter dropped, overflow sticky
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(8'h61 + 8'(i));
            press(codes[i]);
        end
        chk("full_count", 32'(bus.Count), 8);
        chk("full_ovf", 32'(bus.Overflow), 1);
        chk("full_head", 32'(bus.Data), 32'h61);

        // Push and pop on the same edge while full
        exp_q.push_back(8'h6A);
        ev(8'h3B, 1'b1, 1);
        bus.Pop = 1'b1;
        tick(1);
        bus.Pop = 1'b0;
        chk("pp_count", 32'(bus.Count), 8);
        chk("pp_ovf_clr", 32'(bus.Overflow), 0);
        ev(8'h3B, 1'b0, 2);
        pop_n(8);
        chk("ovf_drained", 32'(bus.Count), 0);

        // Asynchronous reset mid-cycle with entries queued and Caps on
        ev(8'h58, 1'b1, 2);
        ev(8'h58, 1'b0, 2);
        press(8'h1C);
        press(8'h32);
        press(8'h21);
        chk("pre_rst_count", 32'(bus.Count), 3);
        chk("pre_rst_caps", 32'(bus.CapsLock), 1);
        #2;
        rst_n = 1'b0;
        bus.KeyCode = 8'h00;
        bus.KeyDown = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.Ready), 0);
        chk("arst_data", 32'(bus.Data), 0);
        chk("arst_count", 32'(bus.Count), 0);
        chk("arst_ovf", 32'(bus.Overflow), 0);
        chk("arst_caps", 32'(bus.CapsLock), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        pop_n(1);
        chk("empty_pop_count", 32'(bus.Count), 0);
        chk("empty_pop_ready", 32'(bus.Ready), 0);
        exp_q.push_back(8'h61);
        ev(8'h1C, 1'b1, 2);
        chk("post_rst_data", 32'(bus.Data), 32'h61);
        ev(8'h1C, 1'b0, 2);
        pop_n(1);
        chk("final_count", 32'(bus.Count), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
